ddr2_port_master: RTL and testbench

//  Client-side initiator for one port of the 5-port DDR2 arbiter. Accepts a burst

---
 rtl/ddr2_port_master.sv | 156 +++++++++++++++
 tb/tb_ddr2_port_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_port_master.sv
// Burst initiator for one port of the 5-port DDR2 arbiter: issues words, packs 128-bit read beats.
// Optional counters (stat_words, stat_stall) are built when DDR2_PORT_STATS_EN is defined.
module ddr2_port_master #(
   parameter int unsigned LEN_W     = 16,
   parameter int unsigned ADDR_STEP = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [30:0]       cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_read,
   input  logic [255:0]      wr_data,
   input  logic [31:0]       wr_mask,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [255:0]      rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              req,
   input  logic              ack,
   output logic [30:0]       addr,
   output logic              read,
   output logic              fin,
   output logic [255:0]      data_i,
   output logic [31:0]       mask,
   input  logic              valid,
`ifdef DDR2_PORT_STATS_EN
   output logic [31:0]       stat_words,
   output logic [31:0]       stat_stall,
`endif
   input  logic [127:0]      data_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

   state_t             state_q;
   logic [30:0]        base_q;
   logic [LEN_W-1:0]   len_q;
   logic               read_q;
   logic [LEN_W-1:0]   issued_q;
   logic [LEN_W-1:0]   received_q;
   logic               toggle_q;
   logic [127:0]       lo_q;
   logic [255:0]       rd_data_q;
   logic               rd_valid_q;
   logic               done_q;

   logic in_issue;
   logic wr_burst;
   logic take;
   logic last;
   logic beat_en;

   always_comb begin
      in_issue  = (state_q == StIssue);
      wr_burst  = in_issue & ~read_q;
      req       = in_issue & (read_q | wr_valid);
      take      = req & ack;
      last      = (issued_q == len_q - LEN_W'(1));
      fin       = req & last;
      addr      = in_issue ? base_q + 31'(issued_q) * 31'(ADDR_STEP) : '0;
      read      = in_issue & read_q;
      wr_ready  = wr_burst & take;
      data_i    = wr_burst ? wr_data : '0;
      mask      = wr_burst ? wr_mask : '0;
      // Beats may overlap the tail of ISSUE; anything outside a read burst is dropped.
      beat_en   = valid & read_q & ((state_q == StIssue) | (state_q == StDrain));
      cmd_ready = (state_q == StIdle);
      rd_data   = rd_data_q;
      rd_valid  = rd_valid_q;
      done      = done_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         base_q     <= '0;
         len_q      <= '0;
         read_q     <= 1'b0;
         issued_q   <= '0;
         received_q <= '0;
         toggle_q   <= 1'b0;
         lo_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;

         if (beat_en) begin
            if (!toggle_q) begin
               lo_q <= data_o;
            end else begin
               rd_data_q  <= {data_o, lo_q};
               rd_valid_q <= 1'b1;
               received_q <= received_q + LEN_W'(1);
            end
            toggle_q <= ~toggle_q;
         end

         case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  base_q     <= cmd_addr;
                  len_q      <= cmd_len;
                  read_q     <= cmd_read;
                  issued_q   <= '0;
                  received_q <= '0;
                  toggle_q   <= 1'b0;
                  if (cmd_len == '0) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (take) begin
                  issued_q <= issued_q + LEN_W'(1);
                  if (last) begin
                     state_q <= read_q ? StDrain : StDone;
                     done_q  <= ~read_q;
                  end
               end
            end
            StDrain: begin
               if (received_q == len_q) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef DDR2_PORT_STATS_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stat_words <= '0;
         stat_stall <= '0;
      end else begin
         if (take && (stat_words != '1)) stat_words <= stat_words + 32'd1;
         if (req && !ack && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr2_port_master.sv
// Directed bench for ddr2_port_master: write/read bursts, stalls, zero length, wrap, reset abort.
module tb_ddr2_port_master;

   logic          CLK = 1'b0;
   logic          RST;
   logic          cmd_valid, cmd_ready, cmd_read;
   logic [30:0]   cmd_addr;
   logic [15:0]   cmd_len;
   logic [255:0]  wr_data, rd_data, data_i;
   logic [31:0]   wr_mask, mask;
   logic          wr_valid, wr_ready, rd_valid, done;
   logic          req, ack, read, fin, valid;
   logic [30:0]   addr;
   logic [127:0]  data_o;
`ifdef DDR2_PORT_STATS_EN
   logic [31:0]   stat_words, stat_stall;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] BeatA = {4{32'hAAAA0001}};
   localparam logic [127:0] BeatB = {4{32'hBBBB0002}};
   localparam logic [127:0] BeatC = {4{32'hCCCC0003}};
   localparam logic [127:0] BeatD = {4{32'hDDDD0004}};
   localparam logic [127:0] BeatE = {4{32'hEEEE0005}};
   localparam logic [127:0] BeatF = {4{32'hFFFF0006}};

   ddr2_port_master #(.LEN_W(16), .ADDR_STEP(8)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .cmd_read  (cmd_read),
      .wr_data   (wr_data),
      .wr_mask   (wr_mask),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .done      (done),
      .req       (req),
      .ack       (ack),
      .addr      (addr),
      .read      (read),
      .fin       (fin),
      .data_i    (data_i),
      .mask      (mask),
      .valid     (valid),
`ifdef DDR2_PORT_STATS_EN
      .stat_words(stat_words),
      .stat_stall(stat_stall),
`endif
      .data_o    (data_o)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start(input logic [30:0] a, input logic [15:0] l, input logic r);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_read  = r;
      #1;
      check("cmd_ready_at_accept", 256'(cmd_ready), 256'(1));
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      RST = 1'b0;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_read = 1'b0;
      wr_data = '0; wr_mask = '0; wr_valid = 1'b0; ack = 1'b0; valid = 1'b0; data_o = '0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_cmd_ready", 256'(cmd_ready), 256'(1));
      check("rst_req", 256'(req), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_rd_valid", 256'(rd_valid), 256'(0));
      check("rst_addr", 256'(addr), 256'(0));
      check("rst_rd_data", rd_data, 256'(0));
      RST = 1'b1;
      tick();

      // Write len=3, ack every cycle
      start(31'h100, 16'd3, 1'b0);
      wr_valid = 1'b1;
      wr_mask  = 32'h0F0F_F0F0;
      ack      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = {8{32'hA5A50000 + 32'(i)}};
         #1;
         check("w1_req", 256'(req), 256'(1));
         check("w1_addr", 256'(addr), 256'(31'h100 + 31'(8 * i)));
         check("w1_fin", 256'(fin), 256'(i == 2));
         check("w1_wr_ready", 256'(wr_ready), 256'(1));
         check("w1_data_i", data_i, {8{32'hA5A50000 + 32'(i)}});
         check("w1_mask", 256'(mask), 256'(32'h0F0F_F0F0));
         check("w1_no_done", 256'(done), 256'(0));
         tick();
      end
      ack = 1'b0; wr_valid = 1'b0;
      #1;
      check("w1_done", 256'(done), 256'(1));
      check("w1_done_not_ready", 256'(cmd_ready), 256'(0));
      check("w1_req_off", 256'(req), 256'(0));
      tick();
      check("w1_done_pulse", 256'(done), 256'(0));
      check("w1_ready_back", 256'(cmd_ready), 256'(1));

      // Read len=2, two idle cycles before each ack, then four beats
      start(31'h2000, 16'd2, 1'b1);
      for (int w = 0; w < 2; w++) begin
         for (int g = 0; g < 2; g++) begin
            ack = 1'b0;
            #1;
            check("r2_req_held", 256'(req), 256'(1));
            check("r2_read", 256'(read), 256'(1));
            check("r2_addr_wait", 256'(addr), 256'(31'h2000 + 31'(8 * w)));
            tick();
         end
         ack = 1'b1;
         #1;
         check("r2_fin", 256'(fin), 256'(w == 1));
         tick();
      end
      ack = 1'b0;
      #1;
      check("r2_drain_req", 256'(req), 256'(0));
      valid = 1'b1; data_o = BeatA; tick();
      data_o = BeatB; tick();
      data_o = BeatC;
      #1;
      check("r2_rv1", 256'(rd_valid), 256'(1));
      check("r2_word1", rd_data, {BeatB, BeatA});
      tick();
      data_o = BeatD;
      #1;
      check("r2_rv_gap", 256'(rd_valid), 256'(0));
      tick();
      valid = 1'b0;
      #1;
      check("r2_rv2", 256'(rd_valid), 256'(1));
      check("r2_word2", rd_data, {BeatD, BeatC});
      check("r2_done_early", 256'(done), 256'(0));
      tick();
      check("r2_done", 256'(done), 256'(1));
      tick();

      // Write len=4 with wr_valid dropped 5 cycles after the first word
      start(31'h300, 16'd4, 1'b0);
      ack = 1'b1; wr_valid = 1'b1;
      #1;
      check("w3_addr0", 256'(addr), 256'(31'h300));
      tick();
      wr_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("w3_stall_req", 256'(req), 256'(0));
         check("w3_stall_wr_ready", 256'(wr_ready), 256'(0));
         check("w3_stall_addr", 256'(addr), 256'(31'h308));
         tick();
      end
      wr_valid = 1'b1;
      for (int i = 1; i < 4; i++) begin
         #1;
         check("w3_req", 256'(req), 256'(1));
         check("w3_addr", 256'(addr), 256'(31'h300 + 31'(8 * i)));
         check("w3_fin", 256'(fin), 256'(i == 3));
         tick();
      end
      wr_valid = 1'b0; ack = 1'b0;
      #1;
      check("w3_done", 256'(done), 256'(1));
      tick();

      // Zero length with stray ack held high
      ack = 1'b1;
      #1;
      check("z_idle_req", 256'(req), 256'(0));
      start(31'h400, 16'd0, 1'b0);
      #1;
      check("z_done", 256'(done), 256'(1));
      check("z_req", 256'(req), 256'(0));
      tick();
      check("z_done_pulse", 256'(done), 256'(0));
      check("z_ready", 256'(cmd_ready), 256'(1));
      ack = 1'b0;

      // Address wrap at 2^31
      start(31'h7FFFFFF8, 16'd2, 1'b0);
      wr_valid = 1'b1; ack = 1'b1;
      #1;
      check("wrap_addr0", 256'(addr), 256'(31'h7FFFFFF8));
      tick();
      check("wrap_addr1", 256'(addr), 256'(0));
      check("wrap_fin", 256'(fin), 256'(1));
      tick();
      wr_valid = 1'b0; ack = 1'b0;
      #1;
      check("wrap_done", 256'(done), 256'(1));
      tick();

      // Reset while draining a read
      start(31'h500, 16'd1, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      valid = 1'b1; data_o = BeatA;
      tick();
      valid = 1'b0;
      #5;
      RST = 1'b0;
      #1;
      check("ra_req", 256'(req), 256'(0));
      check("ra_addr", 256'(addr), 256'(0));
      check("ra_read", 256'(read), 256'(0));
      check("ra_done", 256'(done), 256'(0));
      check("ra_rd_valid", 256'(rd_valid), 256'(0));
      check("ra_rd_data", rd_data, 256'(0));
      check("ra_ready", 256'(cmd_ready), 256'(1));
      #1;
      RST = 1'b1;
      tick();
      check("ra_ready_post", 256'(cmd_ready), 256'(1));
      check("ra_no_done", 256'(done), 256'(0));

      // Stray beat in IDLE must not shift packing of the next read
      valid = 1'b1; data_o = BeatC;
      tick();
      valid = 1'b0;
      start(31'h600, 16'd1, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      valid = 1'b1; data_o = BeatE; tick();
      data_o = BeatF; tick();
      valid = 1'b0;
      #1;
      check("rp_rv", 256'(rd_valid), 256'(1));
      check("rp_word", rd_data, {BeatF, BeatE});
      tick();
      check("rp_done", 256'(done), 256'(1));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
